// File: rtl/pipe_hazard_ctrl.sv
// Pipeline hazard controller: load-use bubbles, jump flushes, memory-wait stalls with timeout, halt.
// Define PIPE_HAZARD_CTRL_PERF_EN to add saturating stall/flush cycle counters.
module pipe_hazard_ctrl #(
  parameter int REGI_BITS   = 4,
  parameter int MEM_TIMEOUT = 15
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 ex_memRead_i,
  input  logic [REGI_BITS-1:0] ex_intRegDest_i,
  input  logic [REGI_BITS-1:0] id_srcA_i,
  input  logic [REGI_BITS-1:0] id_srcB_i,
  input  logic                 id_useA_i,
  input  logic                 id_useB_i,
  input  logic                 mem_memOp_i,
  input  logic                 mem_nop_i,
  input  logic                 mem_jump_i,
  input  logic                 mem_end_i,
  input  logic                 mem_ack_i,
  output logic                 mem_req_o,
  output logic                 pc_en_o,
  output logic                 ifid_en_o,
  output logic                 idex_en_o,
  output logic                 exmem_en_o,
  output logic                 memwb_en_o,
  output logic                 ifid_flush_o,
  output logic                 idex_flush_o,
  output logic                 exmem_flush_o,
  output logic                 halted_o,
  output logic                 err_o
`ifdef PIPE_HAZARD_CTRL_PERF_EN
 ,output logic [15:0]          stall_cnt_o,
  output logic [15:0]          flush_cnt_o
`endif
);

  localparam int CW = $clog2(MEM_TIMEOUT + 1);
  localparam logic [CW-1:0] TIMEOUT_VAL = CW'(MEM_TIMEOUT);

  typedef enum logic [1:0] {RUN, MEM_WAIT, HALT, ERR} state_t;

  state_t        r_state, w_nextState;
  logic [CW-1:0] r_cnt, w_nextCnt;

  logic w_memValid, w_endValid, w_memStall, w_endHit, w_loadUse, w_advance;

  assign w_memValid = mem_memOp_i & ~mem_nop_i;
  assign w_endValid = mem_end_i & ~mem_nop_i;
  assign w_memStall = w_memValid & ~mem_ack_i;
  // An acknowledged memory op takes precedence over an end marker in the same slot.
  assign w_endHit   = w_endValid & ~w_memValid;
  assign w_loadUse  = ex_memRead_i && (ex_intRegDest_i != '0) &&
                      ((id_useA_i && (id_srcA_i == ex_intRegDest_i)) ||
                       (id_useB_i && (id_srcB_i == ex_intRegDest_i)));

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state <= RUN;
      r_cnt   <= '0;
    end else begin
      r_state <= w_nextState;
      r_cnt   <= w_nextCnt;
    end
  end

  always_comb begin
    w_nextState = r_state;
    w_nextCnt   = r_cnt;
    case (r_state)
      RUN: begin
        if (w_memStall) begin
          w_nextState = MEM_WAIT;
          w_nextCnt   = CW'(1);
        end else if (w_endHit) begin
          w_nextState = HALT;
        end else begin
          w_nextCnt   = '0;
        end
      end
      MEM_WAIT: begin
        if (mem_ack_i) begin
          w_nextState = RUN;
          w_nextCnt   = '0;
        end else if (r_cnt >= TIMEOUT_VAL) begin
          w_nextState = ERR;
        end else begin
          w_nextCnt   = r_cnt + CW'(1);
        end
      end
      HALT:    w_nextState = HALT;
      ERR:     w_nextState = ERR;
      default: w_nextState = RUN;
    endcase
  end

  // Outputs are forced low while reset is asserted so a pending request drops immediately.
  always_comb begin
    mem_req_o     = 1'b0;
    pc_en_o       = 1'b0;
    ifid_en_o     = 1'b0;
    idex_en_o     = 1'b0;
    exmem_en_o    = 1'b0;
    memwb_en_o    = 1'b0;
    ifid_flush_o  = 1'b0;
    idex_flush_o  = 1'b0;
    exmem_flush_o = 1'b0;
    halted_o      = 1'b0;
    err_o         = 1'b0;
    w_advance     = 1'b0;
    case (r_state)
      RUN: begin
        mem_req_o = w_memValid;
        if (!w_memStall) begin
          if (w_endHit) memwb_en_o = 1'b1;
          else          w_advance  = 1'b1;
        end
      end
      MEM_WAIT: begin
        mem_req_o = 1'b1;
        w_advance = mem_ack_i;
      end
      HALT:    halted_o = 1'b1;
      ERR:     err_o    = 1'b1;
      default: ;
    endcase
    if (w_advance) begin
      pc_en_o    = 1'b1;
      ifid_en_o  = 1'b1;
      idex_en_o  = 1'b1;
      exmem_en_o = 1'b1;
      memwb_en_o = 1'b1;
      if (mem_jump_i) begin
        ifid_flush_o  = 1'b1;
        idex_flush_o  = 1'b1;
        exmem_flush_o = 1'b1;
      end else if (w_loadUse) begin
        pc_en_o      = 1'b0;
        ifid_en_o    = 1'b0;
        idex_flush_o = 1'b1;
      end
    end
    if (rst_i) begin
      mem_req_o     = 1'b0;
      pc_en_o       = 1'b0;
      ifid_en_o     = 1'b0;
      idex_en_o     = 1'b0;
      exmem_en_o    = 1'b0;
      memwb_en_o    = 1'b0;
      ifid_flush_o  = 1'b0;
      idex_flush_o  = 1'b0;
      exmem_flush_o = 1'b0;
      halted_o      = 1'b0;
      err_o         = 1'b0;
    end
  end

`ifdef PIPE_HAZARD_CTRL_PERF_EN
  logic [15:0] r_stallCnt, r_flushCnt;
  logic        w_anyFlush, w_pipeActive;

  assign w_anyFlush   = ifid_flush_o | idex_flush_o | exmem_flush_o;
  assign w_pipeActive = (r_state == RUN) || (r_state == MEM_WAIT);

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_stallCnt <= '0;
      r_flushCnt <= '0;
    end else begin
      if (w_pipeActive && !pc_en_o && (r_stallCnt != 16'hFFFF))
        r_stallCnt <= r_stallCnt + 16'd1;
      if (w_anyFlush && (r_flushCnt != 16'hFFFF))
        r_flushCnt <= r_flushCnt + 16'd1;
    end
  end

  assign stall_cnt_o = r_stallCnt;
  assign flush_cnt_o = r_flushCnt;
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Self-checking bench for pipe_hazard_ctrl: vector table plus multi-cycle sequences,
// expected outputs queued at drive time and compared mid-cycle.
module tb_pipe_hazard_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       exMemRead = 1'b0;
  logic [3:0] exDest = '0, srcA = '0, srcB = '0;
  logic       useA = 1'b0, useB = 1'b0, memOp = 1'b0, memNop = 1'b0;
  logic       jump = 1'b0, endI = 1'b0, ack = 1'b0;

  logic memReq, pcEn, ifidEn, idexEn, exmemEn, memwbEn;
  logic ifidFl, idexFl, exmemFl, halted, err;

  int vecCount  = 0;
  int missCount = 0;

  // {mem_req, pc_en, ifid_en, idex_en, exmem_en, memwb_en, ifid_fl, idex_fl, exmem_fl, halted, err}
  localparam logic [10:0] ADV   = 11'b0_11111_000_00;
  localparam logic [10:0] LU    = 11'b0_00111_010_00;
  localparam logic [10:0] JMP   = 11'b0_11111_111_00;
  localparam logic [10:0] MACK  = 11'b1_11111_000_00;
  localparam logic [10:0] STALL = 11'b1_00000_000_00;
  localparam logic [10:0] ENDC  = 11'b0_00001_000_00;
  localparam logic [10:0] HALTO = 11'b0_00000_000_10;
  localparam logic [10:0] ERRO  = 11'b0_00000_000_01;
  localparam logic [10:0] ZERO  = 11'b0_00000_000_00;

  typedef struct {
    string       name;
    logic        exMemRead;
    logic [3:0]  exDest, srcA, srcB;
    logic        useA, useB, memOp, memNop, jump, endI, ack;
    logic [10:0] exp;
  } vec_t;

  typedef struct {
    string       name;
    logic [10:0] exp;
  } sb_t;

  sb_t sbQueue[$];

`ifdef PIPE_HAZARD_CTRL_PERF_EN
  logic [15:0] stallCnt, flushCnt;
  int modelStall = 0, modelFlush = 0;
`endif

  pipe_hazard_ctrl #(.REGI_BITS(4), .MEM_TIMEOUT(15)) dut (
    .clk_i(clk), .rst_i(rst),
    .ex_memRead_i(exMemRead), .ex_intRegDest_i(exDest),
    .id_srcA_i(srcA), .id_srcB_i(srcB), .id_useA_i(useA), .id_useB_i(useB),
    .mem_memOp_i(memOp), .mem_nop_i(memNop), .mem_jump_i(jump),
    .mem_end_i(endI), .mem_ack_i(ack),
    .mem_req_o(memReq), .pc_en_o(pcEn), .ifid_en_o(ifidEn), .idex_en_o(idexEn),
    .exmem_en_o(exmemEn), .memwb_en_o(memwbEn),
    .ifid_flush_o(ifidFl), .idex_flush_o(idexFl), .exmem_flush_o(exmemFl),
    .halted_o(halted), .err_o(err)
`ifdef PIPE_HAZARD_CTRL_PERF_EN
   ,.stall_cnt_o(stallCnt), .flush_cnt_o(flushCnt)
`endif
  );

  always #5 clk = ~clk;

  function automatic vec_t mkVec(input string n, input logic mr, input logic [3:0] d,
                                 input logic [3:0] a, input logic [3:0] b, input logic ua,
                                 input logic ub, input logic mo, input logic np,
                                 input logic jp, input logic en, input logic ak,
                                 input logic [10:0] e);
    vec_t v;
    v.name = n; v.exMemRead = mr; v.exDest = d; v.srcA = a; v.srcB = b;
    v.useA = ua; v.useB = ub; v.memOp = mo; v.memNop = np; v.jump = jp;
    v.endI = en; v.ack = ak; v.exp = e;
    return v;
  endfunction

  task automatic applyStimulus(input vec_t v);
    sb_t s;
    exMemRead = v.exMemRead; exDest = v.exDest; srcA = v.srcA; srcB = v.srcB;
    useA = v.useA; useB = v.useB; memOp = v.memOp; memNop = v.memNop;
    jump = v.jump; endI = v.endI; ack = v.ack;
    s.name = v.name; s.exp = v.exp;
    sbQueue.push_back(s);
  endtask

  task automatic checkOutput();
    sb_t s;
    logic [10:0] act;
    if (sbQueue.size() == 0) begin
      missCount++;
      $display("[TB] FAIL scoreboard: got empty queue, expected an entry");
      return;
    end
    s   = sbQueue.pop_front();
    act = {memReq, pcEn, ifidEn, idexEn, exmemEn, memwbEn, ifidFl, idexFl, exmemFl, halted, err};
    vecCount++;
    if (act !== s.exp) begin
      missCount++;
      $display("[TB] FAIL %s: got %b expected %b", s.name, act, s.exp);
    end
`ifdef PIPE_HAZARD_CTRL_PERF_EN
    if (rst) begin
      modelStall = 0;
      modelFlush = 0;
    end
    vecCount++;
    if (stallCnt !== 16'(modelStall) || flushCnt !== 16'(modelFlush)) begin
      missCount++;
      $display("[TB] FAIL %s_perf: got stall %0d flush %0d expected stall %0d flush %0d",
               s.name, stallCnt, flushCnt, modelStall, modelFlush);
    end
    if (!rst) begin
      if (!s.exp[9] && s.exp[1:0] == 2'b00) modelStall++;
      if (s.exp[4:2] != 3'b000) modelFlush++;
    end
`endif
  endtask

  task automatic runCycle(input vec_t v);
    @(posedge clk); #1;
    applyStimulus(v);
    @(negedge clk);
    checkOutput();
  endtask

  task automatic resetDut(input string n);
    @(posedge clk); #1;
    rst = 1'b1;
    applyStimulus(mkVec(n, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, ZERO));
    @(negedge clk);
    checkOutput();
    rst = 1'b0;
  endtask

  vec_t table_v[$];

  initial begin
    table_v.push_back(mkVec("idle",        0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, ADV));
    table_v.push_back(mkVec("loadUseA",    1, 3, 3, 0, 1, 0, 0, 0, 0, 0, 0, LU));
    table_v.push_back(mkVec("afterBubble", 0, 3, 3, 0, 1, 0, 0, 0, 0, 0, 0, ADV));
    table_v.push_back(mkVec("loadUseB",    1, 5, 2, 5, 1, 1, 0, 0, 0, 0, 0, LU));
    table_v.push_back(mkVec("destZero",    1, 0, 0, 0, 1, 1, 0, 0, 0, 0, 0, ADV));
    table_v.push_back(mkVec("useAOff",     1, 7, 7, 0, 0, 0, 0, 0, 0, 0, 0, ADV));
    table_v.push_back(mkVec("noMatch",     1, 7, 6, 8, 1, 1, 0, 0, 0, 0, 0, ADV));
    table_v.push_back(mkVec("notLoad",     0, 9, 9, 9, 1, 1, 0, 0, 0, 0, 0, ADV));
    table_v.push_back(mkVec("jump",        0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, JMP));
    table_v.push_back(mkVec("jumpLoadUse", 1, 3, 3, 0, 1, 0, 0, 0, 1, 0, 0, JMP));
    table_v.push_back(mkVec("memNop",      0, 0, 0, 0, 0, 0, 1, 1, 0, 0, 0, ADV));
    table_v.push_back(mkVec("endNop",      0, 0, 0, 0, 0, 0, 0, 1, 0, 1, 0, ADV));
    table_v.push_back(mkVec("memAckNow",   0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 1, MACK));
    table_v.push_back(mkVec("loadUseBoth", 1, 4, 4, 4, 1, 1, 0, 0, 0, 0, 0, LU));

    // Reset state while rst is held from time zero.
    sbQueue.push_back('{name: "resetState", exp: ZERO});
    @(negedge clk);
    checkOutput();
    rst = 1'b0;

    foreach (table_v[i]) runCycle(table_v[i]);

    // Memory request acknowledged after four stall cycles.
    for (int i = 0; i < 4; i++)
      runCycle(mkVec("memWait", 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, STALL));
    runCycle(mkVec("memAckLate", 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 1, MACK));
    runCycle(mkVec("backToRun",  0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, ADV));

    // End instruction then halt, which ignores further events.
    runCycle(mkVec("endCycle",  0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, ENDC));
    runCycle(mkVec("halted",    0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, HALTO));
    runCycle(mkVec("haltJump",  0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, HALTO));
    resetDut("resetFromHalt");
    runCycle(mkVec("runAfterHalt", 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, ADV));

    // Timeout: one RUN stall plus fifteen MEM_WAIT cycles, then ERR held.
    for (int i = 0; i < 16; i++)
      runCycle(mkVec("timeoutWait", 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, STALL));
    runCycle(mkVec("errState", 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, ERRO));
    runCycle(mkVec("errHeld",  0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 1, ERRO));
    resetDut("resetFromErr");
    runCycle(mkVec("runAfterErr", 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, ADV));

    // Asynchronous reset between clock edges during a memory wait.
    runCycle(mkVec("preRstJump", 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, JMP));
    for (int i = 0; i < 2; i++)
      runCycle(mkVec("waitBeforeRst", 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, STALL));
    @(posedge clk); #1;
    rst = 1'b1;
    applyStimulus(mkVec("rstMidWait", 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, ZERO));
    #1;
    checkOutput();
    @(negedge clk);
    rst = 1'b0;
    runCycle(mkVec("runAfterMidRst", 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, ADV));
    runCycle(mkVec("loadUseFinal",   1, 3, 3, 0, 1, 0, 0, 0, 0, 0, 0, LU));

    $display("== %0d vectors applied, %0d miscompares ==", vecCount, missCount);
    $finish;
  end

endmodule
